// File: rtl/alu_seq.sv
// alu_seq: multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer driving a shared ALU.
// Optional macro ALU_SEQ_SIGNED_EN enables MULS/DIVS via PRE/POST sign fix-up states.
package pkg_reg;
  localparam int unsigned REG_WIDTH = 8;
endpackage

package pkg_alu;
  typedef enum logic [1:0] {
    ALU_NOP = 2'd0,
    ALU_ADD = 2'd1,
    ALU_SUB = 2'd2
  } alu_op_t;
endpackage

module alu_seq #(
  parameter int unsigned WIDTH = pkg_reg::REG_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [WIDTH-1:0]     req_x,
  input  logic [WIDTH-1:0]     req_y,
  input  logic                 flush,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_hi,
  output logic [WIDTH-1:0]     resp_lo,
  output logic                 resp_dz,
  output logic                 resp_err,
  output pkg_alu::alu_op_t     alu_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_s,
  input  logic                 alu_cf
);
  import pkg_alu::*;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DONE
`ifdef ALU_SEQ_SIGNED_EN
    , PRE1, PRE2, POST1, POST2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q, mpl_q, xr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q, dz_q, err_q;
`ifdef ALU_SEQ_SIGNED_EN
  logic             sgn_q, sx_q, sy_q, loz_q;
`endif

  logic [WIDTH-1:0] rem_sh, hsrc;
  logic             ov, cin;

  assign {ov, rem_sh} = {hi_q, lo_q[WIDTH-1]};
  assign hsrc         = mpl_q[0] ? alu_s : hi_q;
  assign cin          = mpl_q[0] & alu_cf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
`ifdef ALU_SEQ_SIGNED_EN
        if (req_op[0] && req_y == '0) state_d = DONE;
        else if (req_op[1])           state_d = PRE1;
        else                          state_d = RUN;
`else
        if (req_op[1] || (req_op[0] && req_y == '0)) state_d = DONE;
        else                                         state_d = RUN;
`endif
      end
`ifdef ALU_SEQ_SIGNED_EN
      PRE1:  state_d = PRE2;
      PRE2:  state_d = RUN;
      RUN:   if (cnt_q == CNT_W'(1)) state_d = sgn_q ? POST1 : DONE;
      POST1: state_d = POST2;
      POST2: state_d = DONE;
`else
      RUN:   if (cnt_q == CNT_W'(1)) state_d = DONE;
`endif
      DONE:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    alu_op = ALU_NOP;
    alu_a  = '0;
    alu_b  = '0;
    if (!flush) begin
      case (state_q)
        RUN: begin
          if (div_q) begin
            alu_op = ALU_SUB;
            alu_a  = xr_q;
            alu_b  = rem_sh;
          end else if (mpl_q[0]) begin
            alu_op = ALU_ADD;
            alu_a  = xr_q;
            alu_b  = hi_q;
          end
        end
`ifdef ALU_SEQ_SIGNED_EN
        PRE1: if (sx_q) begin
          alu_op = ALU_SUB;
          alu_a  = xr_q;
        end
        PRE2: if (sy_q) begin
          alu_op = ALU_SUB;
          alu_a  = mpl_q;
        end
        POST1: if (sx_q ^ sy_q) begin
          alu_op = ALU_SUB;
          alu_a  = lo_q;
        end
        POST2: begin
          if (div_q) begin
            if (sx_q) begin
              alu_op = ALU_SUB;
              alu_a  = hi_q;
            end
          end else if (sx_q ^ sy_q) begin
            alu_op = ALU_ADD;
            alu_a  = ~hi_q;
            alu_b  = WIDTH'(loz_q);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      mpl_q <= '0;
      xr_q  <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
      err_q <= 1'b0;
`ifdef ALU_SEQ_SIGNED_EN
      sgn_q <= 1'b0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
      loz_q <= 1'b0;
`endif
    end else if (!flush) begin
      case (state_q)
        IDLE: if (req_valid) begin
          dz_q  <= 1'b0;
          err_q <= 1'b0;
          div_q <= req_op[0];
          cnt_q <= CNT_W'(WIDTH);
          hi_q  <= '0;
          lo_q  <= '0;
          xr_q  <= req_x;
          mpl_q <= req_y;
`ifdef ALU_SEQ_SIGNED_EN
          sgn_q <= req_op[1];
          sx_q  <= req_op[1] & req_x[WIDTH-1];
          sy_q  <= req_op[1] & req_y[WIDTH-1];
`else
          if (req_op[1]) err_q <= 1'b1;
          else
`endif
          if (req_op[0] && req_y == '0) begin
            dz_q <= 1'b1;
            hi_q <= req_x;
            lo_q <= '1;
          end else if (req_op == 2'b01) begin
            lo_q <= req_x;
            xr_q <= req_y;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (div_q) begin
            hi_q <= (ov || !alu_cf) ? alu_s : rem_sh;
            lo_q <= {lo_q[WIDTH-2:0], ov || !alu_cf};
          end else begin
            // {hi,lo,mplier} shifted right by one, written per word
            hi_q  <= {cin, hsrc[WIDTH-1:1]};
            lo_q  <= {hsrc[0], lo_q[WIDTH-1:1]};
            mpl_q <= {lo_q[0], mpl_q[WIDTH-1:1]};
          end
        end
`ifdef ALU_SEQ_SIGNED_EN
        PRE1: if (sx_q) xr_q <= alu_s;
        PRE2: begin
          // signed divide keeps operands as x/y until magnitudes are known, then moves them to RUN's layout
          if (div_q) begin
            lo_q <= xr_q;
            xr_q <= sy_q ? alu_s : mpl_q;
          end else if (sy_q) begin
            mpl_q <= alu_s;
          end
        end
        POST1: if (sx_q ^ sy_q) begin
          lo_q  <= alu_s;
          loz_q <= (lo_q == '0);
        end
        POST2: begin
          if (div_q) begin
            if (sx_q) hi_q <= alu_s;
          end else if (sx_q ^ sy_q) begin
            hi_q <= alu_s;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;
  assign resp_dz    = dz_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): arithmetic reference model, per-cycle compare, directed vectors.
module tb_alu_seq;
  import pkg_alu::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_x = '0, req_y = '0;
  logic         flush = 1'b0;
  logic         resp_valid, resp_ready = 1'b0;
  logic [W-1:0] resp_hi, resp_lo;
  logic         resp_dz, resp_err;
  alu_op_t      alu_op;
  logic [W-1:0] alu_a, alu_b, alu_s;
  logic         alu_cf;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_dz(resp_dz), .resp_err(resp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cf(alu_cf)
  );

  always #5 clk = ~clk;

  // Shared ALU: ADD gives a+b with carry, SUB gives b-a with borrow.
  always_comb begin
    alu_s  = '0;
    alu_cf = 1'b0;
    case (alu_op)
      ALU_ADD: {alu_cf, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: {alu_cf, alu_s} = {1'b0, alu_b} - {1'b0, alu_a};
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_result(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                       output logic [W-1:0] hi, output logic [W-1:0] lo,
                                       output logic dz, output logic err, output int lat);
    logic [2*W-1:0] p;
    int sx, sy;
    hi = '0; lo = '0; dz = 1'b0; err = 1'b0; lat = W + 1;
`ifndef ALU_SEQ_SIGNED_EN
    if (op[1]) begin
      err = 1'b1; lat = 1;
      return;
    end
`endif
    if (op[0] && y == '0) begin
      dz = 1'b1; hi = x; lo = '1; lat = 1;
      return;
    end
    if (!op[1]) begin
      if (!op[0]) begin
        p = (2*W)'(x) * (2*W)'(y);
        {hi, lo} = p;
      end else begin
        lo = x / y;
        hi = x % y;
      end
    end else begin
      lat = W + 5;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (!op[0]) {hi, lo} = (2*W)'(sx * sy);
      else begin
        lo = W'(sx / sy);
        hi = W'(sx % sy);
      end
    end
  endfunction

  // Reference model: operation in flight, response pending, and the expected response.
  logic         m_busy = 1'b0, m_valid = 1'b0, m_dz = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           m_left = 0;
  logic [W-1:0] r_hi, r_lo;
  logic         r_dz, r_err;
  int           r_lat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_dz <= 1'b0; m_err <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else if (flush) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end else if (!m_busy && !m_valid) begin
      if (req_valid) begin
        model_result(req_op, req_x, req_y, r_hi, r_lo, r_dz, r_err, r_lat);
        m_hi <= r_hi; m_lo <= r_lo; m_dz <= r_dz; m_err <= r_err;
        m_left  <= r_lat - 1;
        m_busy  <= (r_lat > 1);
        m_valid <= (r_lat == 1);
      end
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
      end
    end else if (resp_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_valid));
      chk("resp_valid", 32'(resp_valid), 32'(m_valid));
      chk("resp_dz", 32'(resp_dz), 32'(m_dz));
      chk("resp_err", 32'(resp_err), 32'(m_err));
      if (m_valid) begin
        chk("resp_hi", 32'(resp_hi), 32'(m_hi));
        chk("resp_lo", 32'(resp_lo), 32'(m_lo));
      end
      if (!m_busy) begin
        chk("alu_op_quiet", 32'(alu_op), 32'(ALU_NOP));
        chk("alu_a_quiet", 32'(alu_a), 32'(0));
        chk("alu_b_quiet", 32'(alu_b), 32'(0));
      end
    end
  end

  // Called just after the accept edge; bounded wait for the response, then backpressure and handshake.
  task automatic wait_resp(input string tag, input int lat, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic edz, input logic eerr, input int hold);
    int n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 32'(n + 1), 32'(lat));
    chk({tag, ".hi"}, 32'(resp_hi), 32'(eh));
    chk({tag, ".lo"}, 32'(resp_lo), 32'(el));
    chk({tag, ".dz"}, 32'(resp_dz), 32'(edz));
    chk({tag, ".err"}, 32'(resp_err), 32'(eerr));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".held_valid"}, 32'(resp_valid), 32'(1));
      chk({tag, ".held_lo"}, 32'(resp_lo), 32'(el));
      chk({tag, ".held_ready"}, 32'(req_ready), 32'(0));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".idle_after"}, 32'(req_ready), 32'(1));
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int lat, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic edz, input logic eerr, input int hold);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(tag, lat, eh, el, edz, eerr, hold);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset.req_ready", 32'(req_ready), 32'(1));
    chk("reset.resp_valid", 32'(resp_valid), 32'(0));
    chk("reset.alu_op", 32'(alu_op), 32'(ALU_NOP));
    chk("reset.hi_lo", 32'({resp_hi, resp_lo}), 32'(0));
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    do_op("mulu_ff_ff", 2'b00, 8'hFF, 8'hFF, 9, 8'hFE, 8'h01, 1'b0, 1'b0, 0);
    do_op("divu_200_7", 2'b01, 8'd200, 8'd7, 9, 8'd4, 8'd28, 1'b0, 1'b0, 0);
    do_op("divu_80_1", 2'b01, 8'h80, 8'h01, 9, 8'h00, 8'h80, 1'b0, 1'b0, 0);
    do_op("divu_dz", 2'b01, 8'h5A, 8'h00, 1, 8'h5A, 8'hFF, 1'b1, 1'b0, 0);
    do_op("mulu_3_5", 2'b00, 8'd3, 8'd5, 9, 8'h00, 8'd15, 1'b0, 1'b0, 0);
    do_op("mulu_12_12", 2'b00, 8'd12, 8'd12, 9, 8'h00, 8'h90, 1'b0, 1'b0, 5);
    do_op("divu_7_200", 2'b01, 8'd7, 8'd200, 9, 8'd7, 8'd0, 1'b0, 1'b0, 0);
    do_op("divu_ff_ff", 2'b01, 8'hFF, 8'hFF, 9, 8'd0, 8'd1, 1'b0, 1'b0, 1);
    do_op("mulu_80_2", 2'b00, 8'h80, 8'h02, 9, 8'h01, 8'h00, 1'b0, 1'b0, 0);

    // No accept while DONE, even with req_valid and the handshake in the same cycle.
    req_valid = 1'b1; req_op = 2'b01; req_x = 8'd9; req_y = 8'd0;
    @(posedge clk); #1;
    chk("b2b.dz_done", 32'(resp_valid), 32'(1));
    req_op = 2'b00; req_x = 8'd2; req_y = 8'd3; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("b2b.not_taken", 32'(req_ready), 32'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp("b2b_mulu_2_3", 9, 8'h00, 8'd6, 1'b0, 1'b0, 0);

    // Flush in RUN cycle 3, together with a request; nothing is accepted or answered.
    req_valid = 1'b1; req_op = 2'b00; req_x = 8'd12; req_y = 8'd12;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    chk("flush.idle", 32'(req_ready), 32'(1));
    chk("flush.alu_nop", 32'(alu_op), 32'(ALU_NOP));
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("flush.no_resp", 32'(resp_valid), 32'(0));
    end

    // Flush with a request in IDLE: not accepted.
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_idle.ready", 32'(req_ready), 32'(1));

    // Reset mid-RUN: outputs return to reset values without waiting for a clock.
    req_valid = 1'b1; req_op = 2'b00; req_x = 8'hFF; req_y = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.req_ready", 32'(req_ready), 32'(1));
    chk("rst_mid.resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_mid.hi_lo", 32'({resp_hi, resp_lo}), 32'(0));
    chk("rst_mid.dz_err", 32'({resp_dz, resp_err}), 32'(0));
    chk("rst_mid.alu", 32'({alu_op, alu_a, alu_b}), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_SEQ_SIGNED_EN
    do_op("muls_m3_5", 2'b10, 8'hFD, 8'd5, 13, 8'hFF, 8'hF1, 1'b0, 1'b0, 0);
    do_op("divs_m7_2", 2'b11, 8'hF9, 8'd2, 13, 8'hFF, 8'hFD, 1'b0, 1'b0, 0);
    do_op("muls_m128_m128", 2'b10, 8'h80, 8'h80, 13, 8'h40, 8'h00, 1'b0, 1'b0, 0);
    do_op("divs_dz", 2'b11, 8'hF9, 8'h00, 1, 8'hF9, 8'hFF, 1'b1, 1'b0, 0);
`else
    do_op("muls_err", 2'b10, 8'hFD, 8'd5, 1, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    do_op("divs_err", 2'b11, 8'hF9, 8'd2, 1, 8'h00, 8'h00, 1'b0, 1'b1, 0);
`endif
    do_op("mulu_after", 2'b00, 8'd3, 8'd5, 9, 8'h00, 8'd15, 1'b0, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
